// File: rtl/aes128_inv_key_schedule.sv
// aes128_inv_key_schedule
// Sequential inverse AES-128 key expansion. Loaded with the round-10 key, it
// walks the schedule backwards and presents round keys 10 down to 0, one per
// valid/ready handshake, so the decrypt datapath never needs all 11 keys stored.
//
// Optional build macro INV_KEY_SBOX_REG_EN registers the SubWord output; each
// backward step then spends one extra cycle in CALC with o_valid low.
`timescale 1ns/1ps

module aes128_inv_key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [127:0] i_lastKey,
  input  logic         i_ready,
  output logic [127:0] o_roundKey,
  output logic [3:0]   o_roundNumber,
  output logic         o_valid,
  output logic         o_busy,
  output logic         o_done
);

  // AES forward S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

`ifdef INV_KEY_SBOX_REG_EN
  typedef enum logic [1:0] {IDLE, OUT, CALC, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, OUT, DONE} state_t;
`endif

  state_t state;

  // Round constant for the round whose key is currently presented.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // SubWord(RotWord(w)); byte 0 of a word is its most significant byte.
  function automatic logic [31:0] subRotWord(input logic [31:0] w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  gWord;
  logic [127:0] prevKey;
  logic         handshake;

  assign {w0, w1, w2, w3} = o_roundKey;
  assign handshake        = o_valid & i_ready;

  // Words 1..3 of the previous key fall out of neighbouring XORs; word 0
  // needs G applied to the already recovered word 3.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

`ifdef INV_KEY_SBOX_REG_EN
  logic [31:0] subReg;

  // Capture SubWord(RotWord(p3)) on the handshake; consumed in CALC.
  // NOTE: pure datapath register, always written before it is read, so it
  // carries no reset and stays out of the control reset tree.
  always_ff @(posedge i_clk) begin
    if (state == OUT && handshake) begin
      subReg <= subRotWord(p3);
    end
  end

  // The key register is unchanged during CALC, so p3 and the round index
  // still refer to the key being stepped back from.
  assign gWord = subReg ^ {rcon(o_roundNumber), 24'h000000};
`else
  assign gWord = subRotWord(p3) ^ {rcon(o_roundNumber), 24'h000000};
`endif

  assign p0      = w0 ^ gWord;
  assign prevKey = {p0, p1, p2, p3};

  // Control FSM with registered outputs; reset has priority over everything.
  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge values and the block order does not matter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      o_roundKey    <= '0;
      o_roundNumber <= '0;
      o_valid       <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            o_roundKey    <= i_lastKey;
            o_roundNumber <= NUM_ROUNDS[3:0];
            o_valid       <= 1'b1;
            o_busy        <= 1'b1;
            state         <= OUT;
          end
        end
        OUT: begin
          if (handshake) begin
            if (o_roundNumber == 4'd0) begin
              o_valid <= 1'b0;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              state   <= DONE;
            end else begin
`ifdef INV_KEY_SBOX_REG_EN
              o_valid <= 1'b0;
              state   <= CALC;
`else
              o_roundKey    <= prevKey;
              o_roundNumber <= o_roundNumber - 4'd1;
`endif
            end
          end
        end
`ifdef INV_KEY_SBOX_REG_EN
        CALC: begin
          o_roundKey    <= prevKey;
          o_roundNumber <= o_roundNumber - 4'd1;
          o_valid       <= 1'b1;
          state         <= OUT;
        end
`endif
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
